// File: rtl/ir_tx_arbiter.sv
// Two-requester round-robin arbiter that hands NEC address/command frames to an
// IR transmitter, supervises its start handshake and enforces an idle guard gap.
module ir_tx_arbiter #(
  parameter int GAP_CYCLES    = 4_000_000,
  parameter int START_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] addr0,
  input  logic [7:0] cmd0,
  input  logic [7:0] addr1,
  input  logic [7:0] cmd1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] tx_addr,
  output logic [7:0] tx_cmd,
  output logic       tx_en,
  input  logic       tx_busy,
  output logic       active,
  output logic       err,
  output logic       last_src
);

  localparam int CNT_MAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_TX,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             last_q, last_d;
  logic             ready_q;

  logic             can_grant;
  logic             grant0;
  logic             grant1;
  logic             timeout;

  // ready_q holds off grants for the first cycle after reset release.
  assign can_grant = rst && ready_q && (state_q == S_IDLE);
  assign grant0    = can_grant && req0 && (!req1 || last_q);
  assign grant1    = can_grant && req1 && (!req0 || !last_q);
  assign timeout   = (state_q == S_WAIT_BUSY) && !tx_busy && (cnt_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= 8'h00;
      cmd_q   <= 8'h00;
      last_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      last_q  <= last_d;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (grant0) begin
          addr_d  = addr0;
          cmd_d   = cmd0;
          last_d  = 1'b0;
          state_d = S_START;
        end else if (grant1) begin
          addr_d  = addr1;
          cmd_d   = cmd1;
          last_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_TX;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TX: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // Requests and tx_busy are deliberately ignored until the gap expires.
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pulses are gated by rst so nothing escapes during a reset cycle.
  always_comb begin
    ack0     = grant0;
    ack1     = grant1;
    tx_en    = rst && (state_q == S_START);
    err      = rst && timeout;
    active   = (state_q != S_IDLE);
    tx_addr  = addr_q;
    tx_cmd   = cmd_q;
    last_src = last_q;
  end

endmodule
